fpu_f32_to_int_pipe: RTL and testbench

Pipelined, parametrised converter from IEEE-754 binary32 to a signed or unsigned integer of INT_WIDTH bits. It supports four rounding modes, saturation with IEEE exception flags, and valid/ready flow control. It sits in the FPU datapath next to the other FPU_* conversion units. It is the hardware successor of the combinational F32-to-INT path, and serves both the non-SW_FPU_MODE build and the multi-width integer ALUs.

---
 rtl/fpu_pkg.sv | 41 ++++
 rtl/fpu_f32_to_int_pipe_if.sv | 28 ++
 rtl/fpu_round_sat.sv | 83 ++++++++
 rtl/fpu_f32_to_int_pipe.sv | 191 +++++++++++++++++++
 tb/tb_fpu_f32_to_int_pipe.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the FPU conversion units:
// field layout, operand classes and rounding modes.
package fpu_pkg;

  localparam int F32_BIAS   = 127;
  localparam int F32_MANT_W = 23;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RDN = 2'd2,
    RM_RUP = 2'd3
  } rm_e;

  typedef enum logic [2:0] {
    FC_ZERO = 3'd0,
    FC_SUB  = 3'd1,
    FC_NORM = 3'd2,
    FC_INF  = 3'd3,
    FC_NAN  = 3'd4
  } fclass_e;

  typedef struct packed {
    logic                  sign;
    logic [7:0]            exp;
    logic [F32_MANT_W-1:0] frac;
  } f32_t;

  function automatic fclass_e f32_classify(input f32_t f);
    fclass_e c;
    if (f.exp == 8'd0) begin
      c = (f.frac == {F32_MANT_W{1'b0}}) ? FC_ZERO : FC_SUB;
    end else if (f.exp == 8'hFF) begin
      c = (f.frac == {F32_MANT_W{1'b0}}) ? FC_INF : FC_NAN;
    end else begin
      c = FC_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/fpu_f32_to_int_pipe_if.sv
// Operand/result handshake bundle of the binary32-to-integer converter.
interface fpu_f32_to_int_pipe_if #(
  parameter int INT_WIDTH = 32,
  parameter int TAG_WIDTH = 4
);
  logic                 a_valid;
  logic                 a_ready;
  logic [31:0]          a;
  logic                 a_signed;
  logic [1:0]           a_rm;
  logic [TAG_WIDTH-1:0] a_tag;
  logic                 o_valid;
  logic                 o_ready;
  logic [INT_WIDTH-1:0] o;
  logic [TAG_WIDTH-1:0] o_tag;
  logic                 o_invalid;
  logic                 o_inexact;

  modport master (
    output a_valid, a, a_signed, a_rm, a_tag, o_ready,
    input  a_ready, o_valid, o, o_tag, o_invalid, o_inexact
  );

  modport slave (
    input  a_valid, a, a_signed, a_rm, a_tag, o_ready,
    output a_ready, o_valid, o, o_tag, o_invalid, o_inexact
  );
endinterface

// File: rtl/fpu_round_sat.sv
// Combinational rounding, range check, saturation and exception flags for
// a float-to-integer conversion whose magnitude is already aligned.
module fpu_round_sat
  import fpu_pkg::*;
#(
  parameter int INT_WIDTH = 32
) (
  input  logic                 sign,
  input  logic [INT_WIDTH:0]   mag,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic                 ovf,
  input  logic                 is_nan,
  input  logic                 is_inf,
  input  logic                 is_signed,
  input  rm_e                  rm,
  output logic [INT_WIDTH-1:0] res,
  output logic                 invalid,
  output logic                 inexact
);

  localparam logic [INT_WIDTH+1:0] SPOS_LIM = {3'b000, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH+1:0] SNEG_LIM = {3'b001, {(INT_WIDTH-1){1'b0}}};
  localparam logic [INT_WIDTH-1:0] SMAX     = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] SMIN     = {1'b1, {(INT_WIDTH-1){1'b0}}};

  logic                 inc_s;
  logic [INT_WIDTH+1:0] rnd_s;
  logic                 sat_s;
  logic                 neg_s;

  // Magnitude increment decision and rounded magnitude (one spare carry bit)
  always_comb begin
    inc_s = 1'b0;
    case (rm)
      RM_RNE:  inc_s = guard & (sticky | mag[0]);
      RM_RTZ:  inc_s = 1'b0;
      RM_RDN:  inc_s = sign & (guard | sticky);
      RM_RUP:  inc_s = ~sign & (guard | sticky);
      default: inc_s = 1'b0;
    endcase
    rnd_s = {1'b0, mag} + {{(INT_WIDTH+1){1'b0}}, inc_s};
  end

  // Range check happens after rounding so a rounding carry can still saturate
  always_comb begin
    sat_s = 1'b0;
    neg_s = sign;
    if (is_nan) begin
      sat_s = 1'b1;
      neg_s = 1'b0;
    end else if (is_inf || ovf) begin
      sat_s = 1'b1;
    end else if (is_signed) begin
      if (sign) begin
        sat_s = (rnd_s > SNEG_LIM);
      end else begin
        sat_s = (rnd_s > SPOS_LIM);
      end
    end else begin
      if (sign) begin
        sat_s = (rnd_s != {(INT_WIDTH+2){1'b0}});
      end else begin
        sat_s = (rnd_s[INT_WIDTH+1:INT_WIDTH] != 2'b00);
      end
    end
  end

  // Final value selection and flags
  always_comb begin
    res = {INT_WIDTH{1'b0}};
    if (!sat_s) begin
      res = sign ? ({INT_WIDTH{1'b0}} - rnd_s[INT_WIDTH-1:0]) : rnd_s[INT_WIDTH-1:0];
    end else if (is_signed) begin
      res = neg_s ? SMIN : SMAX;
    end else begin
      res = neg_s ? {INT_WIDTH{1'b0}} : {INT_WIDTH{1'b1}};
    end
    invalid = sat_s;
    inexact = ~sat_s & (guard | sticky);
  end

endmodule

// File: rtl/fpu_f32_to_int_pipe.sv
// Three-stage binary32 to signed/unsigned integer converter with
// valid/ready flow control: unpack, align, round/saturate.
module fpu_f32_to_int_pipe
  import fpu_pkg::*;
#(
  parameter int INT_WIDTH = 32,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  fpu_f32_to_int_pipe_if.slave io
);

  // Integer part (INT_WIDTH+1 bits) above a 24-bit fraction field
  localparam int              AW      = INT_WIDTH + 25;
  localparam logic signed [9:0] EXP_MAX = 10'(INT_WIDTH);

  logic adv1_s, adv2_s, adv3_s, acc_s;
  logic rdy_en_r;

  f32_t                a_f_s;
  fclass_e             cls_s;
  logic signed [9:0]   exp_s;

  logic                 v1_r, sign1_r, sgn1_r;
  fclass_e              cls1_r;
  logic signed [9:0]    exp1_r;
  logic [23:0]          mant1_r;
  rm_e                  rm1_r;
  logic [TAG_WIDTH-1:0] tag1_r;

  logic [6:0]           shamt_s;
  logic [AW-1:0]        wide_s;
  logic [INT_WIDTH:0]   mag2_s;
  logic                 g2_s, st2_s, ovf2_s, nan2_s, inf2_s;

  logic                 v2_r, sign2_r, sgn2_r, g2_r, st2_r, ovf2_r, nan2_r, inf2_r;
  logic [INT_WIDTH:0]   mag2_r;
  rm_e                  rm2_r;
  logic [TAG_WIDTH-1:0] tag2_r;

  logic [INT_WIDTH-1:0] res3_s;
  logic                 inv3_s, inx3_s;

  logic                 v3_r, inv3_r, inx3_r;
  logic [INT_WIDTH-1:0] o3_r;
  logic [TAG_WIDTH-1:0] tag3_r;

  assign adv3_s     = ~v3_r | io.o_ready;
  assign adv2_s     = ~v2_r | adv3_s;
  assign adv1_s     = ~v1_r | adv2_s;
  assign io.a_ready = adv1_s & rdy_en_r;
  assign acc_s      = io.a_valid & io.a_ready;

  assign io.o_valid   = v3_r;
  assign io.o         = o3_r;
  assign io.o_tag     = tag3_r;
  assign io.o_invalid = inv3_r;
  assign io.o_inexact = inx3_r;

  // Keeps a_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rdy_en_r <= 1'b0;
    else       rdy_en_r <= 1'b1;
  end

  // S1 unpack: classify and remove the exponent bias
  always_comb begin
    a_f_s = io.a;
    cls_s = f32_classify(a_f_s);
    exp_s = $signed({2'b00, a_f_s.exp}) - $signed(10'(F32_BIAS));
  end

  // S1 stage register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v1_r    <= 1'b0;
      sign1_r <= 1'b0;
      sgn1_r  <= 1'b0;
      cls1_r  <= FC_ZERO;
      exp1_r  <= 10'sd0;
      mant1_r <= 24'd0;
      rm1_r   <= RM_RNE;
      tag1_r  <= {TAG_WIDTH{1'b0}};
    end else if (adv1_s) begin
      v1_r    <= acc_s;
      sign1_r <= a_f_s.sign;
      sgn1_r  <= io.a_signed;
      cls1_r  <= cls_s;
      exp1_r  <= exp_s;
      mant1_r <= {1'b1, a_f_s.frac};
      rm1_r   <= rm_e'(io.a_rm);
      tag1_r  <= io.a_tag;
    end
  end

  // S2 align: shift by exp+1 so bit 23 of the fraction field is the guard bit
  always_comb begin
    shamt_s = 7'd0;
    wide_s  = {AW{1'b0}};
    mag2_s  = {(INT_WIDTH+1){1'b0}};
    g2_s    = 1'b0;
    st2_s   = 1'b0;
    ovf2_s  = 1'b0;
    nan2_s  = 1'b0;
    inf2_s  = 1'b0;
    case (cls1_r)
      FC_NORM: begin
        if (exp1_r > EXP_MAX) begin
          ovf2_s = 1'b1;
        end else if (exp1_r < -10'sd1) begin
          st2_s = 1'b1;
        end else begin
          shamt_s = 7'(exp1_r + 10'sd1);
          wide_s  = {{(INT_WIDTH+1){1'b0}}, mant1_r} << shamt_s;
          mag2_s  = wide_s[AW-1:24];
          g2_s    = wide_s[23];
          st2_s   = |wide_s[22:0];
        end
      end
      FC_SUB:  st2_s  = 1'b1;
      FC_INF:  inf2_s = 1'b1;
      FC_NAN:  nan2_s = 1'b1;
      default: st2_s  = 1'b0;
    endcase
  end

  // S2 stage register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v2_r    <= 1'b0;
      sign2_r <= 1'b0;
      sgn2_r  <= 1'b0;
      mag2_r  <= {(INT_WIDTH+1){1'b0}};
      g2_r    <= 1'b0;
      st2_r   <= 1'b0;
      ovf2_r  <= 1'b0;
      nan2_r  <= 1'b0;
      inf2_r  <= 1'b0;
      rm2_r   <= RM_RNE;
      tag2_r  <= {TAG_WIDTH{1'b0}};
    end else if (adv2_s) begin
      v2_r    <= v1_r;
      sign2_r <= sign1_r;
      sgn2_r  <= sgn1_r;
      mag2_r  <= mag2_s;
      g2_r    <= g2_s;
      st2_r   <= st2_s;
      ovf2_r  <= ovf2_s;
      nan2_r  <= nan2_s;
      inf2_r  <= inf2_s;
      rm2_r   <= rm1_r;
      tag2_r  <= tag1_r;
    end
  end

  fpu_round_sat #(.INT_WIDTH(INT_WIDTH)) u_round_sat (
    .sign      (sign2_r),
    .mag       (mag2_r),
    .guard     (g2_r),
    .sticky    (st2_r),
    .ovf       (ovf2_r),
    .is_nan    (nan2_r),
    .is_inf    (inf2_r),
    .is_signed (sgn2_r),
    .rm        (rm2_r),
    .res       (res3_s),
    .invalid   (inv3_s),
    .inexact   (inx3_s)
  );

  // S3 output register: holds its value while the consumer stalls
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v3_r   <= 1'b0;
      o3_r   <= {INT_WIDTH{1'b0}};
      tag3_r <= {TAG_WIDTH{1'b0}};
      inv3_r <= 1'b0;
      inx3_r <= 1'b0;
    end else if (adv3_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        o3_r   <= res3_s;
        tag3_r <= tag2_r;
        inv3_r <= inv3_s;
        inx3_r <= inx3_s;
      end
    end
  end

endmodule

// File: tb/tb_fpu_f32_to_int_pipe.sv
// Table-driven scoreboard bench for the binary32-to-integer converter,
// with 32-bit and 16-bit instances plus latency, stall and reset sequences.
module tb_fpu_f32_to_int_pipe;

  typedef struct {
    logic [31:0] a;
    logic        sgn;
    logic [1:0]  rm;
    logic [63:0] o;
    logic        inv;
    logic        inx;
    logic        w16;
  } vec_t;

  typedef struct {
    logic [63:0] o;
    logic        inv;
    logic        inx;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  fpu_f32_to_int_pipe_if #(.INT_WIDTH(32), .TAG_WIDTH(4)) if32 ();
  fpu_f32_to_int_pipe_if #(.INT_WIDTH(16), .TAG_WIDTH(4)) if16 ();

  fpu_f32_to_int_pipe #(.INT_WIDTH(32), .TAG_WIDTH(4)) dut32 (.clk(clk), .nrst(nrst), .io(if32));
  fpu_f32_to_int_pipe #(.INT_WIDTH(16), .TAG_WIDTH(4)) dut16 (.clk(clk), .nrst(nrst), .io(if16));

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q32[$];
  exp_t q16[$];
  int   pop_cyc_q[$];
  exp_t cur32, cur16;
  vec_t tbl[37];
  logic [31:0] bp_a[6];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on acceptance, pop and compare on output transfer
  always @(negedge clk) begin
    exp_t e;
    if (nrst && if32.a_valid && if32.a_ready) q32.push_back(cur32);
    if (nrst && if16.a_valid && if16.a_ready) q16.push_back(cur16);
    if (nrst && if32.o_valid && if32.o_ready) begin
      if (q32.size() == 0) begin
        chk("unexpected_out32", {74'd0, if32.o_tag, if32.o_valid, if32.o_ready}, 80'd0);
      end else begin
        e = q32.pop_front();
        pop_cyc_q.push_back(cyc);
        chk("out32", {10'd0, 32'd0, if32.o, if32.o_tag, if32.o_invalid, if32.o_inexact},
            {10'd0, e.o, e.tag, e.inv, e.inx});
      end
    end
    if (nrst && if16.o_valid && if16.o_ready) begin
      if (q16.size() == 0) begin
        chk("unexpected_out16", {74'd0, if16.o_tag, if16.o_valid, if16.o_ready}, 80'd0);
      end else begin
        e = q16.pop_front();
        chk("out16", {10'd0, 48'd0, if16.o, if16.o_tag, if16.o_invalid, if16.o_inexact},
            {10'd0, e.o, e.tag, e.inv, e.inx});
      end
    end
  end

  task automatic drive(input logic w16, input logic [31:0] a, input logic sgn, input logic [1:0] rm,
                       input logic [3:0] tag, input logic [63:0] eo, input logic einv, input logic einx);
    if (w16) begin
      cur16 = '{eo, einv, einx, tag};
      if16.a = a; if16.a_signed = sgn; if16.a_rm = rm; if16.a_tag = tag; if16.a_valid = 1'b1;
    end else begin
      cur32 = '{eo, einv, einx, tag};
      if32.a = a; if32.a_signed = sgn; if32.a_rm = rm; if32.a_tag = tag; if32.a_valid = 1'b1;
    end
  endtask

  task automatic send(input logic w16, input logic [31:0] a, input logic sgn, input logic [1:0] rm,
                      input logic [3:0] tag, input logic [63:0] eo, input logic einv, input logic einx);
    logic acc;
    acc = 1'b0;
    drive(w16, a, sgn, rm, tag, eo, einv, einx);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = w16 ? (if16.a_valid & if16.a_ready) : (if32.a_valid & if32.a_ready);
      @(posedge clk);
      #1;
    end
    if (w16) if16.a_valid = 1'b0;
    else     if32.a_valid = 1'b0;
    if (!acc) chk("accept_timeout", {79'd0, acc}, 80'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q32.size() != 0 || q16.size() != 0); i++) @(posedge clk);
    #1;
    chk("drain", 80'(q32.size() + q16.size()), 80'd0);
  endtask

  initial begin
    int idx, acc_n;
    logic acc, held_v, held_bad;
    logic [31:0] held_o;
    logic [3:0]  held_t;

    //          a             sgn   rm     expected o              inv   inx   w16
    tbl[0]  = '{32'h40490FDB, 1'b1, 2'd0, 64'h0000_0003, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{32'h3FC00000, 1'b1, 2'd0, 64'h0000_0002, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{32'h40200000, 1'b1, 2'd0, 64'h0000_0002, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{32'h40200000, 1'b1, 2'd1, 64'h0000_0002, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{32'hBFC00000, 1'b1, 2'd2, 64'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{32'hBFC00000, 1'b1, 2'd3, 64'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{32'h4F000000, 1'b1, 2'd0, 64'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{32'hCF000000, 1'b1, 2'd0, 64'h8000_0000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{32'h7FC00000, 1'b1, 2'd0, 64'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{32'h4F000000, 1'b0, 2'd0, 64'h8000_0000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{32'hBF800000, 1'b0, 2'd0, 64'h0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{32'hBE99999A, 1'b0, 2'd1, 64'h0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{32'h00000000, 1'b1, 2'd3, 64'h0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{32'h80000000, 1'b1, 2'd2, 64'h0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{32'h7F800000, 1'b1, 2'd0, 64'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{32'hFF800000, 1'b1, 2'd0, 64'h8000_0000, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{32'h00000001, 1'b1, 2'd3, 64'h0000_0001, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{32'h80000001, 1'b1, 2'd2, 64'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{32'h3F000000, 1'b1, 2'd0, 64'h0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{32'h3F000000, 1'b1, 2'd3, 64'h0000_0001, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{32'h4F800000, 1'b0, 2'd0, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{32'hFF800000, 1'b0, 2'd0, 64'h0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[22] = '{32'h7FC00000, 1'b0, 2'd0, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[23] = '{32'hCF000001, 1'b1, 2'd0, 64'h8000_0000, 1'b1, 1'b0, 1'b0};
    tbl[24] = '{32'h3F800000, 1'b0, 2'd0, 64'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{32'h4EFFFFFF, 1'b1, 2'd0, 64'h7FFF_FF80, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{32'hC0200000, 1'b1, 2'd0, 64'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
    tbl[27] = '{32'hC0200000, 1'b1, 2'd2, 64'hFFFF_FFFD, 1'b0, 1'b1, 1'b0};
    tbl[28] = '{32'h40490FDB, 1'b1, 2'd3, 64'h0000_0004, 1'b0, 1'b1, 1'b0};
    tbl[29] = '{32'h46FFFE00, 1'b1, 2'd0, 64'h0000_7FFF, 1'b0, 1'b0, 1'b1};
    tbl[30] = '{32'h47000000, 1'b1, 2'd0, 64'h0000_7FFF, 1'b1, 1'b0, 1'b1};
    tbl[31] = '{32'h477FFF00, 1'b0, 2'd0, 64'h0000_FFFF, 1'b0, 1'b0, 1'b1};
    tbl[32] = '{32'h46FFFF00, 1'b1, 2'd0, 64'h0000_7FFF, 1'b1, 1'b0, 1'b1};
    tbl[33] = '{32'h46FFFF00, 1'b1, 2'd1, 64'h0000_7FFF, 1'b0, 1'b1, 1'b1};
    tbl[34] = '{32'hC7000000, 1'b1, 2'd0, 64'h0000_8000, 1'b0, 1'b0, 1'b1};
    tbl[35] = '{32'h47800000, 1'b0, 2'd0, 64'h0000_FFFF, 1'b1, 1'b0, 1'b1};
    tbl[36] = '{32'h5F800000, 1'b1, 2'd0, 64'h0000_7FFF, 1'b1, 1'b0, 1'b1};
    bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};

    if32.a_valid = 1'b0; if32.a = 32'd0; if32.a_signed = 1'b0; if32.a_rm = 2'd0;
    if32.a_tag = 4'd0; if32.o_ready = 1'b1;
    if16.a_valid = 1'b0; if16.a = 32'd0; if16.a_signed = 1'b0; if16.a_rm = 2'd0;
    if16.a_tag = 4'd0; if16.o_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out32", {41'd0, if32.a_ready, if32.o_valid, if32.o, if32.o_tag, if32.o_invalid, if32.o_inexact}, 80'd0);
    chk("rst_out16", {57'd0, if16.a_ready, if16.o_valid, if16.o, if16.o_tag, if16.o_invalid, if16.o_inexact}, 80'd0);
    #10 nrst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {78'd0, if32.a_ready, if16.a_ready}, 80'd3);

    // Vector table, streamed back to back
    for (int i = 0; i < 37; i++) begin
      send(tbl[i].w16, tbl[i].a, tbl[i].sgn, tbl[i].rm, 4'(i), tbl[i].o, tbl[i].inv, tbl[i].inx);
    end
    drain();

    // Latency: o_valid rises on the third edge counting the accepting edge
    @(posedge clk); #1;
    drive(1'b0, 32'h40490FDB, 1'b1, 2'd0, 4'd9, 64'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    if32.a_valid = 1'b0;
    chk("lat_e0", {79'd0, if32.o_valid}, 80'd0);
    @(posedge clk); #1;
    chk("lat_e1", {79'd0, if32.o_valid}, 80'd0);
    @(posedge clk); #1;
    chk("lat_e2", {79'd0, if32.o_valid}, 80'd1);
    drain();

    // Backpressure: only three operands fit, outputs hold, then drain in order
    if32.o_ready = 1'b0;
    idx = 0; acc_n = 0; held_v = 1'b0; held_bad = 1'b0; held_o = 32'd0; held_t = 4'd0;
    drive(1'b0, bp_a[0], 1'b1, 2'd0, 4'd0, 64'd1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if32.o_valid) begin
        if (!held_v) begin
          held_v = 1'b1; held_o = if32.o; held_t = if32.o_tag;
        end else if (if32.o !== held_o || if32.o_tag !== held_t) begin
          held_bad = 1'b1;
        end
      end
      acc = if32.a_valid & if32.a_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_n++;
        idx++;
        drive(1'b0, bp_a[idx], 1'b1, 2'd0, 4'(idx), 64'(idx + 1), 1'b0, 1'b0);
      end
    end
    chk("bp_accepted", 80'(acc_n), 80'd3);
    chk("bp_ready_low", {79'd0, if32.a_ready}, 80'd0);
    chk("bp_hold", {78'd0, held_v, held_bad}, 80'd2);
    pop_cyc_q.delete();
    if32.o_ready = 1'b1;
    for (int k = idx; k < 6; k++) send(1'b0, bp_a[k], 1'b1, 2'd0, 4'(k), 64'(k + 1), 1'b0, 1'b0);
    drain();
    chk("bp_count", 80'(pop_cyc_q.size()), 80'd6);
    if (pop_cyc_q.size() == 6) chk("bp_rate", 80'(pop_cyc_q[5] - pop_cyc_q[0]), 80'd5);

    // Reset with three results in flight: nothing stale may surface afterwards
    if32.o_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(1'b0, bp_a[k], 1'b0, 2'd1, 4'(k + 10), 64'(k + 1), 1'b0, 1'b0);
    chk("inflight_valid", {79'd0, if32.o_valid}, 80'd1);
    #2 nrst = 1'b0;
    #1;
    chk("rst_async", {78'd0, if32.o_valid, if32.a_ready}, 80'd0);
    q32.delete();
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    if32.o_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst2", {79'd0, if32.a_ready}, 80'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale", {79'd0, if32.o_valid}, 80'd0);
    send(1'b0, 32'hBFC00000, 1'b1, 2'd0, 4'd15, 64'hFFFF_FFFE, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
